fc_result_argmax: RTL and testbench

Classification readout stage that sits after the second fully-connected layer, on the same shared RAM bus. Once FC2 has stored its ten 8-bit float scores in RAM, this block reads them back, scans them sequentially for the largest value, and reports the winning digit (0-9), its score and an overflow flag. It is enabled and acknowledged with the same ena/done pairing as the other layer blocks, and it releases the shared address bus when disabled.

---
 rtl/fc_result_argmax.sv | 142 ++++++++++++++
 tb/tb_fc_result_argmax.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_result_argmax.sv
`default_nettype none
// ============================================================================
// Module   : fc_result_argmax
// Brief    : Reads the ten float8 FC2 scores back from shared RAM and reports
//            the index and value of the largest one.
// Revision : 1.0 - initial release
// ============================================================================
module fc_result_argmax #(
    parameter logic [31:0] RAM_ADDR_BASE = 32'h0000_3000,
    parameter int          NUM_CLASSES   = 10
) (
    input  logic          clk,
    input  logic          iRst,
    input  logic          ena,
    input  logic [1023:0] data_from_ram,
    input  logic          overflow_in,
    output logic [31:0]   addr_to_ram,
    output logic          done,
    output logic [3:0]    digit,
    output logic [7:0]    max_score,
    output logic          overflow
);

    localparam int         c_VEC_W    = 8 * NUM_CLASSES;
    localparam logic [3:0] c_LAST_IDX = 4'(NUM_CLASSES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ASK  = 2'd1;
    localparam logic [1:0] S_SCAN = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_next;
    logic [31:0]        r_addr;
    logic [c_VEC_W-1:0] r_scores;
    logic [7:0]         r_best;
    logic [3:0]         r_idx;
    logic [3:0]         r_i;
    logic               r_done;
    logic [3:0]         r_digit;
    logic [7:0]         r_max;
    logic               r_overflow;
    logic [7:0]         w_cand;
    logic               w_drive;
    logic               w_unused_bits;

    assign w_unused_bits = ^data_from_ram[1023:c_VEC_W];

    // Sign-magnitude compare; a zero magnitude counts as non-negative so +0 == -0.
    function automatic logic f_gt(input logic [7:0] a, input logic [7:0] b);
        logic neg_a;
        logic neg_b;
        neg_a = a[7] & (|a[6:0]);
        neg_b = b[7] & (|b[6:0]);
        if (neg_a != neg_b)
            return neg_b;
        else if (!neg_a)
            return a[6:0] > b[6:0];
        else
            return a[6:0] < b[6:0];
    endfunction

    always_comb begin
        w_cand = 8'h00;
        for (int k = 0; k < NUM_CLASSES; k++) begin
            if (r_i == 4'(k))
                w_cand = r_scores[k*8 +: 8];
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (ena) w_next = S_ASK;
            S_ASK:   w_next = S_SCAN;
            S_SCAN:  if (r_i == c_LAST_IDX) w_next = S_DONE;
            S_DONE:  w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
        if (!ena)
            w_next = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (iRst) begin
            r_state    <= S_IDLE;
            r_addr     <= 32'h0;
            r_scores   <= '0;
            r_best     <= 8'h00;
            r_idx      <= 4'h0;
            r_i        <= 4'h0;
            r_done     <= 1'b0;
            r_digit    <= 4'h0;
            r_max      <= 8'h00;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_next;
            if (!ena) begin
                r_done <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_addr <= RAM_ADDR_BASE;
                        r_done <= 1'b0;
                    end
                    S_ASK: begin
                        r_scores   <= data_from_ram[c_VEC_W-1:0];
                        r_best     <= data_from_ram[7:0];
                        r_idx      <= 4'h0;
                        r_i        <= 4'h1;
                        r_overflow <= overflow_in;
                    end
                    S_SCAN: begin
                        // Strictly greater only, so ties keep the lowest index.
                        if (f_gt(w_cand, r_best)) begin
                            r_best <= w_cand;
                            r_idx  <= r_i;
                        end
                        if (r_i != c_LAST_IDX)
                            r_i <= r_i + 4'h1;
                    end
                    S_DONE: begin
                        r_digit <= r_idx;
                        r_max   <= r_best;
                        r_done  <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // The shared bus is released immediately when disabled or in reset.
    assign w_drive     = (r_state != S_IDLE) && ena && !iRst;
    assign addr_to_ram = w_drive ? r_addr : 32'hz;
    assign done        = r_done;
    assign digit       = r_digit;
    assign max_score   = r_max;
    assign overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_fc_result_argmax.sv
`default_nettype none
// ============================================================================
// Module   : tb_fc_result_argmax
// Brief    : Randomised scoreboard bench for fc_result_argmax.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fc_result_argmax;

    localparam logic [31:0] c_BASE = 32'h0000_3000;

    typedef struct {
        logic [3:0] digit;
        logic [7:0] score;
        logic       ovf;
    } exp_t;

    logic          clk;
    logic          iRst;
    logic          ena;
    logic [1023:0] data_from_ram;
    logic          overflow_in;
    tri0  [31:0]   addr_to_ram;
    logic          done;
    logic [3:0]    digit;
    logic [7:0]    max_score;
    logic          overflow;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t q_exp[$];
    logic r_done_q = 1'b0;

    fc_result_argmax #(
        .RAM_ADDR_BASE (c_BASE),
        .NUM_CLASSES   (10)
    ) u_dut (
        .clk           (clk),
        .iRst          (iRst),
        .ena           (ena),
        .data_from_ram (data_from_ram),
        .overflow_in   (overflow_in),
        .addr_to_ram   (addr_to_ram),
        .done          (done),
        .digit         (digit),
        .max_score     (max_score),
        .overflow      (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: map each score to a signed integer, argmax with first-wins ties.
    function automatic int f_key(input logic [7:0] s);
        int m;
        m = int'(s[6:0]);
        return s[7] ? -m : m;
    endfunction

    function automatic exp_t f_model(input logic [79:0] v, input logic ovf);
        int   best_k;
        exp_t e;
        best_k = 0;
        for (int k = 1; k < 10; k++)
            if (f_key(v[k*8 +: 8]) > f_key(v[best_k*8 +: 8]))
                best_k = k;
        e.digit = 4'(best_k);
        e.score = v[best_k*8 +: 8];
        e.ovf   = ovf;
        return e;
    endfunction

    function automatic logic [79:0] f_fill(input logic [7:0] b);
        logic [79:0] v;
        for (int k = 0; k < 10; k++)
            v[k*8 +: 8] = b;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops one expectation per rising edge of done.
    always @(negedge clk) begin
        if (done === 1'b1 && r_done_q !== 1'b1) begin
            if (q_exp.size() == 0) begin
                chk("unexpected done", 32'(done), 32'h0);
            end else begin
                exp_t e;
                e = q_exp.pop_front();
                chk("digit", 32'(digit), 32'(e.digit));
                chk("max_score", 32'(max_score), 32'(e.score));
                chk("overflow", 32'(overflow), 32'(e.ovf));
            end
        end
        r_done_q <= done;
    end

    task automatic setup(input logic [79:0] v, input logic ovf);
        for (int j = 0; j < 32; j++)
            data_from_ram[j*32 +: 32] = $urandom;
        data_from_ram[79:0] = v;
        overflow_in = ovf;
    endtask

    // Runs from edge E0 (ena already high) through completion and ena release.
    task automatic wait_done(input exp_t e);
        int cnt;
        tick();
        chk("addr driven", addr_to_ram, c_BASE);
        cnt = 0;
        while (done !== 1'b1 && cnt < 20) begin
            tick();
            cnt++;
            if (cnt == 1) begin
                data_from_ram[31:0]  = $urandom;
                data_from_ram[63:32] = $urandom;
                data_from_ram[79:64] = 16'($urandom);
                overflow_in          = ~overflow_in;
            end
        end
        chk("done latency", 32'(cnt), 32'd11);
        repeat (2) tick();
        chk("done held", 32'(done), 32'h1);
        ena = 1'b0;
        tick();
        chk("done cleared", 32'(done), 32'h0);
        chk("addr released", addr_to_ram, 32'h0);
        chk("digit kept", 32'(digit), 32'(e.digit));
    endtask

    task automatic run_op(input logic [79:0] v, input logic ovf);
        exp_t e;
        e = f_model(v, ovf);
        q_exp.push_back(e);
        setup(v, ovf);
        ena = 1'b1;
        wait_done(e);
    endtask

    initial begin
        logic [79:0] v;
        logic [79:0] v1;
        logic [7:0]  pool [6];
        exp_t        e;

        pool = '{8'h00, 8'h80, 8'h81, 8'h01, 8'h7F, 8'hFF};
        iRst = 1'b1;
        ena  = 1'b1;
        data_from_ram = '0;
        overflow_in   = 1'b0;

        repeat (3) tick();
        chk("rst done", 32'(done), 32'h0);
        chk("rst digit", 32'(digit), 32'h0);
        chk("rst max_score", 32'(max_score), 32'h0);
        chk("rst overflow", 32'(overflow), 32'h0);
        chk("rst addr", addr_to_ram, 32'h0);
        ena = 1'b0;
        tick();
        iRst = 1'b0;
        tick();

        v1 = f_fill(8'h20);
        v1[63:56] = 8'h5A;
        run_op(v1, 1'b0);

        v = f_fill(8'h30);
        v[23:16] = 8'h48;
        v[47:40] = 8'h48;
        run_op(v, 1'b0);

        for (int k = 0; k < 10; k++)
            v[k*8 +: 8] = 8'h90 + 8'(k);
        v[39:32] = 8'h81;
        run_op(v, 1'b0);

        v = f_fill(8'hC0);
        v[7:0]  = 8'h80;
        v[15:8] = 8'h00;
        run_op(v, 1'b0);

        // Abort at E5, then restart with the first scenario.
        setup(v1, 1'b0);
        ena = 1'b1;
        repeat (5) tick();
        chk("abort addr driven", addr_to_ram, c_BASE);
        ena = 1'b0;
        tick();
        chk("abort done", 32'(done), 32'h0);
        chk("abort addr released", addr_to_ram, 32'h0);
        repeat (12) tick();
        chk("abort done stays low", 32'(done), 32'h0);
        run_op(v1, 1'b0);

        // Reset pulse at E6 with ena held high; the restart captures overflow_in=1.
        setup(v1, 1'b1);
        ena = 1'b1;
        repeat (6) tick();
        iRst = 1'b1;
        tick();
        chk("midrst done", 32'(done), 32'h0);
        chk("midrst digit", 32'(digit), 32'h0);
        chk("midrst max_score", 32'(max_score), 32'h0);
        chk("midrst overflow", 32'(overflow), 32'h0);
        chk("midrst addr", addr_to_ram, 32'h0);
        iRst = 1'b0;
        e = f_model(v1, 1'b1);
        q_exp.push_back(e);
        wait_done(e);

        for (int t = 0; t < 24; t++) begin
            for (int k = 0; k < 10; k++)
                v[k*8 +: 8] = (t % 2 == 1) ? 8'($urandom) : pool[$urandom_range(0, 5)];
            run_op(v, 1'($urandom));
        end

        repeat (3) tick();
        chk("scoreboard drained", 32'(q_exp.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
